// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start/data/parity/stop recovery with majority vote,
// break detection, character timeout and a first-word-fall-through RX FIFO.
module uart_rx_engine #(
    parameter int OVERSAMPLE   = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int TIMEOUT_BITS = 40,
    localparam int ADDR_BITS   = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic                 ov_tick_i,
    input  logic                 rx_i,
    input  logic [1:0]           data_width_i,
    input  logic [1:0]           parity_mode_i,
    input  logic                 stop_bits_i,
    input  logic [ADDR_BITS:0]   threshold_i,
    input  logic                 fifo_read_i,
    input  logic                 fifo_flush_i,
    output logic [7:0]           data_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 fifo_empty_o,
    output logic                 fifo_full_o,
    output logic [ADDR_BITS:0]   fifo_count_o,
    output logic                 threshold_irq_o,
    output logic                 timeout_irq_o,
    output logic                 rx_idle_o
);

    localparam int CW       = $clog2(OVERSAMPLE);
    localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]      MID_A    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]      MID_B    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0]      MID_C    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0]      TO_MAX   = TW'(TO_LIMIT);
    localparam logic [ADDR_BITS:0] DEPTH_V  = (ADDR_BITS + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_s, rx_s_d;
    logic [CW-1:0]        cnt;
    logic                 s0, s1, maj;
    logic [2:0]           bit_idx, last_idx;
    logic [7:0]           data_r;
    logic                 par_r, stop1_r, second_stop;
    logic                 tick_dec, tick_end, start_det, par_en, wr_en;
    logic                 frame_err, parity_err, brk;
    logic [10:0]          mem [FIFO_DEPTH];
    logic [10:0]          head;
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 full, empty, pop, push, overrun_r;
    logic [TW-1:0]        to_cnt;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign tick_dec  = ov_tick_i && (cnt == MID_C);
    assign tick_end  = ov_tick_i && (cnt == CNT_LAST);
    assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign start_det = enable_i && rx_s_d && !rx_s;
    assign par_en    = !parity_mode_i[1];
    assign last_idx  = {1'b0, data_width_i} + 3'd4;

    assign frame_err  = !maj || (stop_bits_i && !stop1_r);
    assign brk        = (data_r == '0) && !(par_en && par_r) && !maj && !(stop_bits_i && stop1_r);
    assign parity_err = par_en && (^data_r ^ par_r ^ parity_mode_i[0]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        case (state)
            IDLE:      if (start_det) state_next = START;
            START: begin
                if (tick_dec && maj)  state_next = IDLE;
                else if (tick_end)    state_next = DATA;
            end
            DATA:      if (tick_end && bit_idx == last_idx) state_next = par_en ? PARITY : STOP;
            PARITY:    if (tick_end) state_next = STOP;
            STOP: begin
                if (tick_dec && (!stop_bits_i || second_stop)) begin
                    wr_en      = 1'b1;
                    state_next = frame_err ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (fifo_flush_i) begin
            state_next = WAIT_HIGH;
            wr_en      = 1'b0;
        end
    end

    // Bit timing and sampling; everything restarts from zero while the line is idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt         <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            bit_idx     <= '0;
            data_r      <= '0;
            par_r       <= 1'b0;
            stop1_r     <= 1'b1;
            second_stop <= 1'b0;
        end else if (state == IDLE) begin
            cnt         <= '0;
            bit_idx     <= '0;
            data_r      <= '0;
            second_stop <= 1'b0;
        end else if (ov_tick_i) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == MID_A) s0 <= rx_s;
            if (cnt == MID_B) s1 <= rx_s;
            if (cnt == MID_C) begin
                case (state)
                    DATA:    data_r[bit_idx] <= maj;
                    PARITY:  par_r <= maj;
                    STOP:    if (!second_stop) stop1_r <= maj;
                    default: ;
                endcase
            end
            if (cnt == CNT_LAST) begin
                if (state == DATA) bit_idx <= bit_idx + 1'b1;
                if (state == STOP) second_stop <= 1'b1;
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == DEPTH_V);
    assign pop   = fifo_read_i && !empty;
    assign push  = wr_en && (!full || pop);

    // A pop in the same cycle makes room, so a write into a full FIFO is only dropped without one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_r <= 1'b0;
        end else if (fifo_flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop)                 overrun_r <= 1'b0;
            else if (wr_en && !push) overrun_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {brk, parity_err, frame_err, data_r};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            to_cnt <= '0;
        else if (fifo_flush_i || pop || (state == IDLE && start_det))
            to_cnt <= '0;
        else if (ov_tick_i && state == IDLE && rx_s && !empty && to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
    end

    assign head            = mem[rd_ptr];
    assign data_o          = empty ? 8'h00 : head[7:0];
    assign frame_err_o     = !empty && head[8];
    assign parity_err_o    = !empty && head[9];
    assign break_o         = !empty && head[10];
    assign overrun_o       = overrun_r;
    assign fifo_empty_o    = empty;
    assign fifo_full_o     = full;
    assign fifo_count_o    = count;
    assign threshold_irq_o = (threshold_i != '0) && (count >= threshold_i);
    assign timeout_irq_o   = (to_cnt == TO_MAX);
    assign rx_idle_o       = (state == IDLE);

endmodule
